// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH independent up/down counters with limit, wrap/saturate, tc and sticky ovf.
// Optional snapshot capture enabled by defining MULTI_CHANNEL_COUNTER_SNAPSHOT_EN.
module multi_channel_counter #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_CH    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up,
    input  logic [NUM_CH-1:0]       sat_mode,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH*WIDTH-1:0] limit,
    input  logic [NUM_CH-1:0]       clear_ovf,
    input  logic                    snap,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH*WIDTH-1:0] snap_count,
    output logic                    snap_valid
);

    localparam int TW = NUM_CH * WIDTH;

    logic [TW-1:0]     count_q;
    logic [TW-1:0]     count_d;
    logic [NUM_CH-1:0] tc_q;
    logic [NUM_CH-1:0] tc_d;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH-1:0]  lim;
    logic              set;

    always_comb begin
        count_d = count_q;
        tc_d    = '0;
        ovf_d   = '0;
        cur     = '0;
        lim     = '0;
        set     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur = count_q[i*WIDTH +: WIDTH];
            lim = limit[i*WIDTH +: WIDTH];
            set = 1'b0;
            if (load[i]) begin
                count_d[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                if (up[i]) begin
                    if (cur >= lim) begin
                        tc_d[i] = 1'b1;
                        set     = ~sat_mode[i];
                        count_d[i*WIDTH +: WIDTH] = sat_mode[i] ? lim : '0;
                    end else begin
                        count_d[i*WIDTH +: WIDTH] = cur + 1'b1;
                    end
                end else begin
                    if (cur == '0) begin
                        tc_d[i] = 1'b1;
                        set     = ~sat_mode[i];
                        count_d[i*WIDTH +: WIDTH] = sat_mode[i] ? '0 : lim;
                    end else begin
                        count_d[i*WIDTH +: WIDTH] = cur - 1'b1;
                    end
                end
            end
            // a wrap in the same cycle as a clear keeps the flag set
            ovf_d[i] = set | (ovf_q[i] & ~clear_ovf[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= {NUM_CH{RESET_VAL}};
            tc_q    <= '0;
            ovf_q   <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

`ifdef MULTI_CHANNEL_COUNTER_SNAPSHOT_EN
    logic [TW-1:0] snap_q;
    logic          snap_v_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_q   <= '0;
            snap_v_q <= 1'b0;
        end else begin
            snap_v_q <= snap;
            if (snap) begin
                snap_q <= count_q;
            end
        end
    end

    assign snap_count = snap_q;
    assign snap_valid = snap_v_q;
`else
    logic unused_snap;
    assign unused_snap = snap;
    assign snap_count  = '0;
    assign snap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_channel_counter.sv
// Scoreboard bench for multi_channel_counter: directed scenarios then random traffic
// against an arithmetic reference model.
module tb_multi_channel_counter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TW = W * N;
    localparam int RV = 0;
    localparam int M  = 1 << W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  en, up, sat_mode, load, clear_ovf;
    logic [TW-1:0] load_val, limit;
    logic          snap;
    logic [TW-1:0] count, snap_count;
    logic [N-1:0]  tc, ovf;
    logic          snap_valid;

    multi_channel_counter #(.WIDTH(W), .NUM_CH(N), .RESET_VAL(RV[W-1:0])) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .limit(limit), .clear_ovf(clear_ovf),
        .snap(snap), .count(count), .tc(tc), .ovf(ovf),
        .snap_count(snap_count), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] cnt;
        logic [N-1:0]  tc;
        logic [N-1:0]  ovf;
        logic [TW-1:0] sc;
        logic          sv;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_cnt[N];
    bit   m_ovf[N];
    int   m_sc[N];

    function automatic int fld(input logic [TW-1:0] v, input int i);
        return int'(v[i*W +: W]);
    endfunction

    // reference model: advance one clock using the currently driven inputs
    task automatic tick();
        exp_t e;
        int   pre[N];
        for (int i = 0; i < N; i++) pre[i] = m_cnt[i];
        e.tc = '0;
        for (int i = 0; i < N; i++) begin
            int  c, lim;
            bit  wrapped;
            c = m_cnt[i];
            lim = fld(limit, i);
            wrapped = 0;
            if (!reset_n) begin
                m_cnt[i] = RV;
                m_ovf[i] = 0;
            end else begin
                if (load[i]) begin
                    m_cnt[i] = fld(load_val, i);
                end else if (en[i] && up[i]) begin
                    if (c >= lim) begin
                        e.tc[i] = 1'b1;
                        if (sat_mode[i]) m_cnt[i] = lim;
                        else begin m_cnt[i] = 0; wrapped = 1; end
                    end else m_cnt[i] = (c + 1) % M;
                end else if (en[i]) begin
                    if (c == 0) begin
                        e.tc[i] = 1'b1;
                        if (sat_mode[i]) m_cnt[i] = 0;
                        else begin m_cnt[i] = lim; wrapped = 1; end
                    end else m_cnt[i] = c - 1;
                end
                m_ovf[i] = wrapped || (m_ovf[i] && !clear_ovf[i]);
            end
        end
`ifdef MULTI_CHANNEL_COUNTER_SNAPSHOT_EN
        e.sv = reset_n && snap;
        for (int i = 0; i < N; i++) begin
            if (!reset_n) m_sc[i] = 0;
            else if (snap) m_sc[i] = pre[i];
        end
`else
        e.sv = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            e.cnt[i*W +: W] = m_cnt[i][W-1:0];
            e.ovf[i]        = m_ovf[i];
            e.sc[i*W +: W]  = m_sc[i][W-1:0];
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [TW-1:0] act,
                       input logic [TW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", count, e.cnt);
                chk("tc", TW'(tc), TW'(e.tc));
                chk("ovf", TW'(ovf), TW'(e.ovf));
                chk("snap_valid", TW'(snap_valid), TW'(e.sv));
                chk("snap_count", snap_count, e.sc);
            end
        end
    end

    task automatic set_lim(input int i, input int v);
        limit[i*W +: W] = v[W-1:0];
    endtask

    task automatic set_lv(input int i, input int v);
        load_val[i*W +: W] = v[W-1:0];
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_sc[i] = 0;
        end
        reset_n = 0; en = '0; up = '1; sat_mode = '0; load = '0;
        clear_ovf = '0; load_val = '0; limit = '0; snap = 0;

        // reset, then wrap up-count on channel 0 with limit 5
        repeat (2) tick();
        reset_n = 1;
        set_lim(0, 5);
        en = 4'b0001;
        repeat (8) tick();

        // saturating down-count on channel 1 after loading 3
        en = '0;
        load = 4'b0010; set_lv(1, 3);
        tick();
        load = '0;
        up[1] = 0; sat_mode[1] = 1; en = 4'b0010;
        repeat (6) tick();

        // wrap down on channel 2, clear, then clear colliding with a wrap
        en = 4'b0100; up[2] = 0; sat_mode[2] = 0; set_lim(2, 10);
        tick();
        en = '0; clear_ovf = 4'b0100;
        tick();
        clear_ovf = '0; load = 4'b0100; set_lv(2, 0);
        tick();
        load = '0; en = 4'b0100; clear_ovf = 4'b0100;
        tick();
        en = '0; clear_ovf = '0;
        tick();

        // load beats enable and may exceed limit; reset beats load
        load = 4'b1000; en = 4'b1000; up[3] = 1; set_lv(3, 200); set_lim(3, 50);
        tick();
        load = '0;
        tick();
        load = 4'b1000; reset_n = 0;
        tick();
        load = '0; reset_n = 1; en = '0;
        tick();

        // snapshot of running counts, single then back-to-back
        en = '1; up = '1; sat_mode = '0;
        for (int i = 0; i < N; i++) set_lim(i, 255);
        repeat (3) tick();
        snap = 1; tick();
        snap = 0; repeat (2) tick();
        snap = 1; repeat (3) tick();
        snap = 0; tick();
        snap = 1; reset_n = 0; tick();
        snap = 0; reset_n = 1; tick();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            reset_n   = ($urandom_range(0, 59) != 0);
            en        = N'($urandom);
            up        = N'($urandom);
            sat_mode  = N'($urandom);
            load      = N'($urandom) & N'($urandom) & N'($urandom);
            clear_ovf = N'($urandom) & N'($urandom);
            snap      = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                set_lv(i, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                                       : $urandom_range(0, 20));
                if ($urandom_range(0, 9) == 0)
                    set_lim(i, ($urandom_range(0, 5) == 0) ? 255
                                                           : $urandom_range(0, 15));
            end
            tick();
        end

        reset_n = 1; en = '0; load = '0; snap = 0; clear_ovf = '0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", TW'(q.size()), TW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
